// File: rtl/mlp_seq_engine_pkg.sv
// Shared types and fixed-point helpers for the sequential MLP engine.
// Activation select, FSM states, weight-store sizing, multiply and clamp.
package mlp_seq_engine_pkg;

  typedef enum logic [1:0] {
    ACT_LINEAR  = 2'd0,
    ACT_RELU    = 2'd1,
    ACT_SIGMOID = 2'd2,
    ACT_TANH    = 2'd3
  } act_func_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_MAC,
    S_ACT,
    S_DONE
  } state_e;

  function automatic int mlp_weight_count(
    input int n_in,
    input int hs,
    input int nl,
    input int n_out
  );
    return hs * (n_in + 1)
         + (nl - 1) * hs * (hs + 1)
         + n_out * (hs + 1);
  endfunction

  // Operands up to 32 bits; full-width signed product.
  function automatic logic signed [63:0] fx_mul(
    input logic signed [31:0] a,
    input logic signed [31:0] b
  );
    logic signed [63:0] ae;
    logic signed [63:0] be;
    ae = {{32{a[31]}}, a};
    be = {{32{b[31]}}, b};
    return ae * be;
  endfunction

  function automatic logic signed [63:0] fx_sat(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mlp_seq_engine_act.sv
// Combinational fixed-point activation: linear, relu,
// hard sigmoid and hard tanh.
module mlp_activation_unit
  import mlp_seq_engine_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  act_func_e                act_i,
  input  logic signed [DATA_W-1:0] x_i,
  output logic signed [DATA_W-1:0] y_o
);

  localparam int XW    = DATA_W + 2;
  localparam int ONE_I = 1 << FRAC_W;

  logic signed [XW-1:0] xw;
  logic signed [XW-1:0] sg;
  logic signed [XW-1:0] one;

  assign one = XW'(ONE_I);
  assign xw  = XW'(x_i);
  // x/4 + 0.5 with floor rounding of the quarter
  assign sg  = (xw >>> 2) + XW'(ONE_I / 2);

  always_comb begin
    y_o = x_i;
    unique case (act_i)
      ACT_LINEAR: y_o = x_i;
      ACT_RELU:   y_o = x_i[DATA_W-1] ? '0 : x_i;
      ACT_SIGMOID: begin
        if (sg < 0)        y_o = '0;
        else if (sg > one) y_o = DATA_W'(one);
        else               y_o = DATA_W'(sg);
      end
      ACT_TANH: begin
        if (xw > one)       y_o = DATA_W'(one);
        else if (xw < -one) y_o = DATA_W'(-one);
        else                y_o = x_i;
      end
      default: y_o = x_i;
    endcase
  end

endmodule

// File: rtl/mlp_seq_engine.sv
// Time-multiplexed MLP engine: one shared MAC, on-chip weight store.
// Optional MLP_SAT_EN: saturate (instead of wrap) when narrowing acc.
module mlp_seq_engine
  import mlp_seq_engine_pkg::*;
#(
  parameter int N_IN            = 2,
  parameter int HIDDEN_SIZE     = 4,
  parameter int N_HIDDEN_LAYERS = 1,
  parameter int N_OUT           = 1,
  parameter int DATA_W          = 16,
  parameter int FRAC_W          = 8,
  parameter int WADDR_W = $clog2(mlp_weight_count(
    N_IN, HIDDEN_SIZE, N_HIDDEN_LAYERS, N_OUT))
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*DATA_W-1:0]  in_data,
  input  act_func_e               hidden_act,
  input  act_func_e               output_act,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  input  logic                    wr_en,
  input  logic [WADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  output logic                    wr_err,
  output logic                    busy
);

  localparam int N_WORDS = mlp_weight_count(
    N_IN, HIDDEN_SIZE, N_HIDDEN_LAYERS, N_OUT);
  localparam int MAX_FAN = (N_IN > HIDDEN_SIZE) ? N_IN : HIDDEN_SIZE;
  localparam int MAXN    = (MAX_FAN > N_OUT) ? MAX_FAN : N_OUT;
  localparam int IW      = (MAXN > 1) ? $clog2(MAXN) : 1;
  localparam int LW      = $clog2(N_HIDDEN_LAYERS + 1);
  localparam int ACC_W   = 2 * DATA_W + $clog2(MAX_FAN + 1);

  state_e                   state_q, state_d;
  logic                     rdy_q;
  logic [LW-1:0]            lay_q, lay_d;
  logic [IW-1:0]            neu_q, neu_d;
  logic [IW-1:0]            k_q, k_d;
  logic [WADDR_W-1:0]       base_q, base_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     wbank_q, wbank_d;
  act_func_e                hact_q, hact_d;
  act_func_e                oact_q, oact_d;
  logic [N_OUT*DATA_W-1:0]  out_q, out_d;
  logic                     wr_err_q;

  logic signed [DATA_W-1:0] wmem  [N_WORDS];
  logic signed [DATA_W-1:0] in_q  [MAXN];
  logic signed [DATA_W-1:0] buf_q [2][MAXN];

  logic signed [DATA_W-1:0] w_rd, x_k, r_nar, act_y;
  logic [WADDR_W-1:0]       rd_addr;
  logic                     is_out, accept;
  int                       fan_in, n_neu;
  act_func_e                act_sel;

  assign is_out  = (lay_q == LW'(N_HIDDEN_LAYERS));
  assign fan_in  = (lay_q == '0) ? N_IN : HIDDEN_SIZE;
  assign n_neu   = is_out ? N_OUT : HIDDEN_SIZE;
  assign accept  = (state_q == S_IDLE) && rdy_q && in_valid;
  assign rd_addr = base_q + ((state_q == S_BIAS) ?
                   WADDR_W'(fan_in) : WADDR_W'(k_q));
  assign w_rd    = wmem[rd_addr];
  assign x_k     = (lay_q == '0) ? in_q[k_q] : buf_q[~wbank_q][k_q];
  assign act_sel = is_out ? oact_q : hact_q;

`ifdef MLP_SAT_EN
  assign r_nar = DATA_W'(fx_sat(64'(acc_q >>> FRAC_W), DATA_W));
`else
  assign r_nar = DATA_W'(acc_q >>> FRAC_W);
`endif

  mlp_activation_unit #(
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W)
  ) u_act (
    .act_i(act_sel),
    .x_i  (r_nar),
    .y_o  (act_y)
  );

  always_comb begin
    state_d = state_q;
    lay_d   = lay_q;
    neu_d   = neu_q;
    k_d     = k_q;
    base_d  = base_q;
    acc_d   = acc_q;
    wbank_d = wbank_q;
    hact_d  = hact_q;
    oact_d  = oact_q;
    out_d   = out_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_BIAS;
          lay_d   = '0;
          neu_d   = '0;
          k_d     = '0;
          base_d  = '0;
          wbank_d = 1'b0;
          hact_d  = hidden_act;
          oact_d  = output_act;
        end
      end
      S_BIAS: begin
        acc_d   = ACC_W'(w_rd) <<< FRAC_W;
        k_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_q + ACC_W'(fx_mul(32'(w_rd), 32'(x_k)));
        if (k_q == IW'(fan_in - 1)) state_d = S_ACT;
        else                        k_d = k_q + IW'(1);
      end
      S_ACT: begin
        base_d = base_q + WADDR_W'(fan_in + 1);
        if (is_out) out_d[int'(neu_q)*DATA_W +: DATA_W] = act_y;
        state_d = S_BIAS;
        if (neu_q == IW'(n_neu - 1)) begin
          neu_d = '0;
          if (is_out) begin
            state_d = S_DONE;
          end else begin
            lay_d   = lay_q + LW'(1);
            wbank_d = ~wbank_q;
          end
        end else begin
          neu_d = neu_q + IW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rdy_q    <= 1'b0;
      lay_q    <= '0;
      neu_q    <= '0;
      k_q      <= '0;
      base_q   <= '0;
      acc_q    <= '0;
      wbank_q  <= 1'b0;
      hact_q   <= ACT_LINEAR;
      oact_q   <= ACT_LINEAR;
      out_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= 1'b1;
      lay_q    <= lay_d;
      neu_q    <= neu_d;
      k_q      <= k_d;
      base_q   <= base_d;
      acc_q    <= acc_d;
      wbank_q  <= wbank_d;
      hact_q   <= hact_d;
      oact_q   <= oact_d;
      out_q    <= out_d;
      wr_err_q <= wr_en && (state_q != S_IDLE);
    end
  end

  // Storage is deliberately left out of reset; weights survive rst.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == S_IDLE) && (int'(wr_addr) < N_WORDS))
      wmem[wr_addr] <= wr_data;
    if (accept)
      for (int i = 0; i < N_IN; i++)
        in_q[i] <= in_data[i*DATA_W +: DATA_W];
    if ((state_q == S_ACT) && !is_out)
      buf_q[wbank_q][neu_q] <= act_y;
  end

  assign in_ready  = (state_q == S_IDLE) && rdy_q;
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_q;
  assign wr_err    = wr_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule
